// File: rtl/stat_update_scheduler.sv
// Serialises every write to the pet's five stats: four edge-triggered user requests
// (round-robin) and a periodic decay tick (strict priority), one update per FSM pass.
module stat_update_scheduler #(
    parameter int TICK_DIV  = 50000000,
    parameter int COOLDOWN  = 4,
    parameter int STAT_INIT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       feeding,
    input  logic       light_out,
    input  logic       echo_sig,
    input  logic       healing,
    output logic [2:0] foodValue,
    output logic [2:0] sleepValue,
    output logic [2:0] funValue,
    output logic [2:0] happyValue,
    output logic [2:0] healthValue,
    output logic [3:0] grant,
    output logic       decay_active,
    output logic       busy
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [2:0] INIT = 3'(STAT_INIT);

    typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, DECAY = 2'd2, COOL = 2'd3} state_t;

    function automatic logic [2:0] sat_add2(input logic [2:0] v);
        return (v >= 3'd5) ? 3'd7 : v + 3'd2;
    endfunction

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    function automatic logic [2:0] happy_of(input logic [2:0] f, input logic [2:0] s,
                                            input logic [2:0] u, input logic [2:0] h);
        logic [4:0] sum;
        sum = {2'b00, f} + {2'b00, s} + {2'b00, u} + {2'b00, h};
        return 3'(sum >> 2);
    endfunction

    state_t        state_r, state_n;
    logic [DW-1:0] cool_r, cool_n;
    logic [CW-1:0] tick_r;
    logic          decay_pend_r, decay_pend_n, dclr_s;
    logic [3:0]    pending_r, pending_n, clr_s;
    logic [3:0]    prev_r, req_s, edge_s;
    logic [1:0]    ptr_r, ptr_n, pick_s;
    logic          found_s, wrap_s;
    logic [3:0]    grant_r, grant_n;
    logic          decay_active_r, decay_active_n;
    logic          busy_r;
    logic [2:0]    food_r, sleep_r, fun_r, happy_r, health_r;
    logic [2:0]    food_n, sleep_n, fun_n, happy_n, health_n;

    assign req_s  = {healing, echo_sig, light_out, feeding};
    assign edge_s = req_s & ~prev_r;
    assign wrap_s = (tick_r == CW'(TICK_DIV - 1));

    // Free-running decay tick divider, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= {CW{1'b0}};
        end else if (wrap_s) begin
            tick_r <= {CW{1'b0}};
        end else begin
            tick_r <= tick_r + CW'(1);
        end
    end

    // Round-robin search of pending requests starting at the pointer.
    always_comb begin
        found_s = 1'b0;
        pick_s  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!found_s && pending_r[ptr_r + 2'(k)]) begin
                found_s = 1'b1;
                pick_s  = ptr_r + 2'(k);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, arbitration and saturating stat arithmetic.
    always_comb begin
        state_n        = state_r;
        cool_n         = cool_r;
        clr_s          = 4'b0000;
        dclr_s         = 1'b0;
        ptr_n          = ptr_r;
        grant_n        = 4'b0000;
        decay_active_n = 1'b0;
        food_n         = food_r;
        sleep_n        = sleep_r;
        fun_n          = fun_r;
        health_n       = health_r;
        happy_n        = happy_r;
        case (state_r)
            IDLE: begin
                if (decay_pend_r) begin
                    dclr_s         = 1'b1;
                    decay_active_n = 1'b1;
                    state_n        = DECAY;
                end else if (found_s) begin
                    grant_n = 4'b0001 << pick_s;
                    clr_s   = 4'b0001 << pick_s;
                    ptr_n   = pick_s + 2'd1;
                    state_n = APPLY;
                end else begin
                    state_n = IDLE;
                end
            end
            APPLY: begin
                case (grant_r)
                    4'b0001: food_n   = sat_add2(food_r);
                    4'b0010: sleep_n  = sat_add2(sleep_r);
                    4'b0100: begin
                        fun_n  = sat_add2(fun_r);
                        food_n = sat_dec(food_r);
                    end
                    4'b1000: health_n = sat_add2(health_r);
                    default: food_n   = food_r;
                endcase
                happy_n = happy_of(food_n, sleep_n, fun_n, health_n);
                cool_n  = {DW{1'b0}};
                state_n = COOL;
            end
            DECAY: begin
                food_n  = sat_dec(food_r);
                sleep_n = sat_dec(sleep_r);
                fun_n   = sat_dec(fun_r);
                // Health only suffers when a basic need was already exhausted.
                if (food_r == 3'd0 || sleep_r == 3'd0 || fun_r == 3'd0) begin
                    health_n = sat_dec(health_r);
                end else begin
                    health_n = health_r;
                end
                happy_n = happy_of(food_n, sleep_n, fun_n, health_n);
                cool_n  = {DW{1'b0}};
                state_n = COOL;
            end
            COOL: begin
                if (cool_r == DW'(COOLDOWN - 1)) begin
                    state_n = IDLE;
                end else begin
                    cool_n = cool_r + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        pending_n    = (pending_r & ~clr_s) | edge_s;
        decay_pend_n = (decay_pend_r & ~dclr_s) | wrap_s;
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            cool_r         <= {DW{1'b0}};
            decay_pend_r   <= 1'b0;
            pending_r      <= 4'b0000;
            prev_r         <= 4'b0000;
            ptr_r          <= 2'd0;
            grant_r        <= 4'b0000;
            decay_active_r <= 1'b0;
            busy_r         <= 1'b0;
            food_r         <= INIT;
            sleep_r        <= INIT;
            fun_r          <= INIT;
            happy_r        <= INIT;
            health_r       <= INIT;
        end else begin
            state_r        <= state_n;
            cool_r         <= cool_n;
            decay_pend_r   <= decay_pend_n;
            pending_r      <= pending_n;
            prev_r         <= req_s;
            ptr_r          <= ptr_n;
            grant_r        <= grant_n;
            decay_active_r <= decay_active_n;
            busy_r         <= (state_n != IDLE);
            food_r         <= food_n;
            sleep_r        <= sleep_n;
            fun_r          <= fun_n;
            happy_r        <= happy_n;
            health_r       <= health_n;
        end
    end

    assign foodValue    = food_r;
    assign sleepValue   = sleep_r;
    assign funValue     = fun_r;
    assign happyValue   = happy_r;
    assign healthValue  = health_r;
    assign grant        = grant_r;
    assign decay_active = decay_active_r;
    assign busy         = busy_r;
endmodule

// File: tb/tb_stat_update_scheduler.sv
// Bench for stat_update_scheduler: directed scenarios plus randomized requests checked
// against a timestamp-based reference model of the scheduling rules.
module tb_stat_update_scheduler;
    localparam int TD = 16;
    localparam int CD = 2;
    localparam int SI = 5;

    logic clk = 1'b0;
    logic rst, feeding, light_out, echo_sig, healing;
    logic [2:0] foodValue, sleepValue, funValue, happyValue, healthValue;
    logic [3:0] grant;
    logic decay_active, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: stats as integers, decisions as timestamps.
    int m_food, m_sleep, m_fun, m_health, m_happy;
    int m_ptr, m_n, m_free_at, m_upd_at, m_kind;
    bit [3:0] m_pend, m_prev;
    bit m_dpend, m_dact, m_busy;
    logic [3:0] m_grant;

    stat_update_scheduler #(.TICK_DIV(TD), .COOLDOWN(CD), .STAT_INIT(SI)) dut (
        .clk(clk), .rst(rst), .feeding(feeding), .light_out(light_out),
        .echo_sig(echo_sig), .healing(healing), .foodValue(foodValue),
        .sleepValue(sleepValue), .funValue(funValue), .happyValue(happyValue),
        .healthValue(healthValue), .grant(grant), .decay_active(decay_active), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int up2(input int v);
        return (v + 2 > 7) ? 7 : v + 2;
    endfunction

    function automatic int dn1(input int v);
        return (v == 0) ? 0 : v - 1;
    endfunction

    task automatic model_step();
        bit [3:0] ins, edges;
        bit hurt;
        if (rst) begin
            m_food = SI; m_sleep = SI; m_fun = SI; m_health = SI; m_happy = SI;
            m_pend = 4'b0; m_prev = 4'b0; m_dpend = 1'b0; m_ptr = 0; m_n = 0;
            m_free_at = 0; m_upd_at = -1; m_grant = 4'b0; m_dact = 1'b0; m_busy = 1'b0;
            return;
        end
        m_n++;
        ins = {healing, echo_sig, light_out, feeding};
        edges = ins & ~m_prev;
        m_prev = ins;
        if (m_upd_at == m_n) begin
            if (m_kind == 4) begin
                hurt = (m_food == 0) || (m_sleep == 0) || (m_fun == 0);
                m_food = dn1(m_food); m_sleep = dn1(m_sleep); m_fun = dn1(m_fun);
                if (hurt) m_health = dn1(m_health);
            end else if (m_kind == 0) m_food = up2(m_food);
            else if (m_kind == 1) m_sleep = up2(m_sleep);
            else if (m_kind == 2) begin m_fun = up2(m_fun); m_food = dn1(m_food); end
            else m_health = up2(m_health);
            m_happy = (m_food + m_sleep + m_fun + m_health) / 4;
        end
        m_grant = 4'b0;
        m_dact = 1'b0;
        if (m_n >= m_free_at) begin
            if (m_dpend) begin
                m_dpend = 1'b0; m_kind = 4; m_dact = 1'b1;
                m_upd_at = m_n + 1; m_free_at = m_n + 2 + CD;
            end else if (m_pend != 4'b0) begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 4;
                    if (m_grant == 4'b0 && m_pend[idx]) begin
                        m_grant[idx] = 1'b1; m_pend[idx] = 1'b0; m_kind = idx;
                        m_ptr = (idx + 1) % 4;
                        m_upd_at = m_n + 1; m_free_at = m_n + 2 + CD;
                    end
                end
            end
        end
        m_pend = m_pend | edges;
        if (m_n % TD == 0) m_dpend = 1'b1;
        m_busy = (m_n + 1 < m_free_at);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; feeding = 1'b0; light_out = 1'b0; echo_sig = 1'b0; healing = 1'b0;
        step(); step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({foodValue, sleepValue, funValue, healthValue, happyValue} !== {5{3'd5}}) begin n_bad++; $display("FAIL reset_stats: got %h want all 5", {foodValue, sleepValue, funValue, healthValue, happyValue}); end
        n_cmp++; if ({busy, decay_active, grant} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: got busy=%b dact=%b grant=%b want 0", busy, decay_active, grant); end
        while (cyc < 17) step();
        n_cmp++; if (decay_active !== 1'b1) begin n_bad++; $display("FAIL decay_active: got %b want 1", decay_active); end
        step();
        n_cmp++; if ({foodValue, sleepValue, funValue, healthValue, happyValue} !== {3'd4, 3'd4, 3'd4, 3'd5, 3'd4}) begin n_bad++; $display("FAIL first_decay: got f%0d s%0d u%0d h%0d hp%0d want 4 4 4 5 4", foodValue, sleepValue, funValue, healthValue, happyValue); end
    endtask

    task automatic test_feed();
        do_reset();
        feeding = 1'b1; step(); feeding = 1'b0; step();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL feed_grant: got %b want 0001", grant); end
        step();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL feed_grant_once: got %b want 0000", grant); end
        n_cmp++; if ({foodValue, happyValue} !== {3'd7, 3'd5}) begin n_bad++; $display("FAIL feed_food: got food=%0d happy=%0d want 7 5", foodValue, happyValue); end
        feeding = 1'b1; step(); feeding = 1'b0;
        while (cyc < 8) step();
        n_cmp++; if (foodValue !== 3'd7) begin n_bad++; $display("FAIL feed_saturate: got %0d want 7", foodValue); end
    endtask

    task automatic test_all_four();
        logic [3:0] g[4];
        int gc[4];
        int ng;
        ng = 0;
        do_reset();
        {healing, echo_sig, light_out, feeding} = 4'b1111; step();
        {healing, echo_sig, light_out, feeding} = 4'b0000;
        while (cyc < 15) begin
            step();
            if (grant !== 4'b0000 && ng < 4) begin g[ng] = grant; gc[ng] = cyc; ng++; end
        end
        n_cmp++; if (ng !== 4) begin n_bad++; $display("FAIL rr_count: got %0d grants want 4", ng); end
        for (int i = 0; i < ng; i++) begin
            n_cmp++; if (g[i] !== (4'b0001 << i)) begin n_bad++; $display("FAIL rr_order: grant %0d got %b want %b", i, g[i], 4'b0001 << i); end
            if (i > 0) begin
                n_cmp++; if (gc[i] - gc[i-1] !== 2 + CD) begin n_bad++; $display("FAIL rr_spacing: got %0d want %0d", gc[i] - gc[i-1], 2 + CD); end
            end
        end
        n_cmp++; if ({foodValue, sleepValue, funValue, healthValue} !== {3'd6, 3'd7, 3'd7, 3'd7}) begin n_bad++; $display("FAIL rr_stats: got f%0d s%0d u%0d h%0d want 6 7 7 7", foodValue, sleepValue, funValue, healthValue); end
    endtask

    task automatic test_decay_priority();
        do_reset();
        while (cyc < 15) step();
        echo_sig = 1'b1; step(); echo_sig = 1'b0; step();
        n_cmp++; if ({decay_active, grant} !== 5'b10000) begin n_bad++; $display("FAIL prio_decay_first: got dact=%b grant=%b want 1 0000", decay_active, grant); end
        step();
        n_cmp++; if ({funValue, foodValue} !== {3'd4, 3'd4}) begin n_bad++; $display("FAIL prio_after_decay: got fun=%0d food=%0d want 4 4", funValue, foodValue); end
        while (cyc < 21) step();
        n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL prio_play_grant: got %b want 0100", grant); end
        step();
        n_cmp++; if ({funValue, foodValue} !== {3'd6, 3'd3}) begin n_bad++; $display("FAIL prio_after_play: got fun=%0d food=%0d want 6 3", funValue, foodValue); end
    endtask

    task automatic test_starve();
        do_reset();
        while (cyc < 82) step();
        n_cmp++; if ({foodValue, healthValue} !== {3'd0, 3'd5}) begin n_bad++; $display("FAIL starve_5: got food=%0d health=%0d want 0 5", foodValue, healthValue); end
        while (cyc < 98) step();
        n_cmp++; if ({foodValue, healthValue} !== {3'd0, 3'd4}) begin n_bad++; $display("FAIL starve_6: got food=%0d health=%0d want 0 4", foodValue, healthValue); end
        while (cyc < 114) step();
        n_cmp++; if ({foodValue, sleepValue, healthValue} !== {3'd0, 3'd0, 3'd3}) begin n_bad++; $display("FAIL starve_7: got food=%0d sleep=%0d health=%0d want 0 0 3", foodValue, sleepValue, healthValue); end
    endtask

    task automatic test_hold_and_reset();
        int gcount;
        int waited;
        gcount = 0;
        waited = 0;
        do_reset();
        feeding = 1'b1;
        repeat (20) begin step(); if (grant !== 4'b0000) gcount++; end
        feeding = 1'b0;
        n_cmp++; if (gcount !== 1) begin n_bad++; $display("FAIL hold_one_grant: got %0d want 1", gcount); end
        step();
        feeding = 1'b1;
        while (grant === 4'b0000 && waited < 20) begin step(); waited++; end
        n_cmp++; if (grant === 4'b0000) begin n_bad++; $display("FAIL mid_reset_wait: got no grant within %0d cycles want grant", waited); end
        rst = 1'b1; feeding = 1'b0; step(); rst = 1'b0; cyc = 0;
        n_cmp++; if ({foodValue, sleepValue, funValue, healthValue, busy, grant} !== {3'd5, 3'd5, 3'd5, 3'd5, 1'b0, 4'b0}) begin n_bad++; $display("FAIL mid_reset: got f%0d s%0d u%0d h%0d busy=%b grant=%b want 5 5 5 5 0 0000", foodValue, sleepValue, funValue, healthValue, busy, grant); end
        gcount = 0;
        repeat (6) begin step(); if (grant !== 4'b0000) gcount++; end
        n_cmp++; if (gcount !== 0) begin n_bad++; $display("FAIL mid_reset_pending: got %0d grants want 0", gcount); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) feeding = ~feeding;
            if ($urandom_range(5) == 0) light_out = ~light_out;
            if ($urandom_range(5) == 0) echo_sig = ~echo_sig;
            if ($urandom_range(5) == 0) healing = ~healing;
            rst = ($urandom_range(399) == 0);
            step();
            n_cmp++; if ({foodValue, sleepValue, funValue, happyValue, healthValue} !== {3'(m_food), 3'(m_sleep), 3'(m_fun), 3'(m_happy), 3'(m_health)}) begin n_bad++; $display("FAIL rand_stats @%0d: got %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d", i, foodValue, sleepValue, funValue, happyValue, healthValue, m_food, m_sleep, m_fun, m_happy, m_health); end
            n_cmp++; if ({grant, decay_active, busy} !== {m_grant, m_dact, m_busy}) begin n_bad++; $display("FAIL rand_ctrl @%0d: got grant=%b dact=%b busy=%b want %b %b %b", i, grant, decay_active, busy, m_grant, m_dact, m_busy); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; feeding = 1'b0; light_out = 1'b0; echo_sig = 1'b0; healing = 1'b0;
        test_reset();
        test_feed();
        test_all_four();
        test_decay_priority();
        test_starve();
        test_hold_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
